cpu_alu_arbiter: RTL and testbench

- Shares one combinational CPU ALU between REQUESTERS independent clients, e.g. the execute stage, a branch-compare unit and a CSR/debug path.
- Each client issues a level request carrying op, op1 and op2. The arbiter picks one client round-robin, drives the ALU from registered operands, captures the result and compare flag, then returns them to the granted client with a one-cycle ready pulse.
- Sits between the pipeline clients and the ALU instance; it contains no arithmetic of its own.

---
 rtl/cpu_alu_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_cpu_alu_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_alu_arbiter.sv
// Purpose : round-robin arbiter sharing one combinational ALU between
//           REQUESTERS clients; registers the operands, captures the result.
// Latency : grant edge -> EXECUTE -> RESPOND; o_ready pulses in the cycle after
//           the second edge that sees the request.
// Backpr. : clients hold i_request + operands until their one-cycle o_ready
//           pulse; one op per 2 cycles with several clients, 3 with one.
// Ports   : i_clock/i_reset (async, active-high); i_request/i_op/i_op1/i_op2
//           per-client, packed by client index; o_ready one-hot pulse;
//           o_result/o_compare_result shared registered result; o_busy;
//           o_alu_* / i_alu_* connect to the external ALU.
// Option  : `define CPU_ALU_ARBITER_PERF_EN adds o_grant_count/o_stall_count.
module cpu_alu_arbiter #(
   parameter int REQUESTERS = 2,
   parameter int IDW        = 3
) (
   input  logic                     i_clock,
   input  logic                     i_reset,
   input  logic [REQUESTERS-1:0]    i_request,
   input  logic [4*REQUESTERS-1:0]  i_op,
   input  logic [32*REQUESTERS-1:0] i_op1,
   input  logic [32*REQUESTERS-1:0] i_op2,
   output logic [REQUESTERS-1:0]    o_ready,
   output logic [31:0]              o_result,
   output logic                     o_compare_result,
   output logic                     o_busy,
   output logic [3:0]               o_alu_op,
   output logic [31:0]              o_alu_op1,
   output logic [31:0]              o_alu_op2,
   input  logic [31:0]              i_alu_result,
   input  logic                     i_alu_compare_result
`ifdef CPU_ALU_ARBITER_PERF_EN
   ,
   output logic [31:0]              o_grant_count,
   output logic [31:0]              o_stall_count
`endif
);

   typedef enum logic [1:0] {IDLE, EXECUTE, RESPOND} state_t;

   state_t          state_q, state_d;
   logic [IDW-1:0]  ptr_q, ptr_d;
   logic [IDW-1:0]  id_q, id_d;
   logic [3:0]      op_q, op_d;
   logic [31:0]     op1_q, op1_d;
   logic [31:0]     op2_q, op2_d;
   logic [31:0]     result_q, result_d;
   logic            cmp_q, cmp_d;

   logic [REQUESTERS-1:0] id_onehot;
   logic                  id_valid;
   logic [REQUESTERS-1:0] eligible;
   logic                  found;
   int                    win_idx;
   logic                  grant;
   logic [3:0]            sel_op;
   logic [31:0]           sel_op1;
   logic [31:0]           sel_op2;

   // An out-of-range latched id decodes to all-zero, which suppresses o_ready.
   always_comb begin : decode_id
      id_onehot = '0;
      for (int k = 0; k < REQUESTERS; k++) begin
         id_onehot[k] = (int'(id_q) == k);
      end
      id_valid = |id_onehot;
   end

   // The in-flight client still holds its request until after o_ready, so it
   // is masked out while the arbiter is busy.
   always_comb begin : eligibility
      if (state_q == IDLE) eligible = i_request;
      else                 eligible = i_request & ~id_onehot;
   end

   // Rotating scan starting at ptr_q; ptr_q is always < REQUESTERS, so a
   // single subtraction covers the wrap.
   always_comb begin : rr_scan
      int idx;
      found   = 1'b0;
      win_idx = 0;
      idx     = 0;
      for (int i = 0; i < REQUESTERS; i++) begin
         idx = int'(ptr_q) + i;
         if (idx >= REQUESTERS) idx = idx - REQUESTERS;
         for (int k = 0; k < REQUESTERS; k++) begin
            if ((k == idx) && !found && eligible[k]) begin
               found   = 1'b1;
               win_idx = k;
            end
         end
      end
   end

   always_comb begin : operand_mux
      sel_op  = '0;
      sel_op1 = '0;
      sel_op2 = '0;
      for (int k = 0; k < REQUESTERS; k++) begin
         if (k == win_idx) begin
            sel_op  = i_op[4*k +: 4];
            sel_op1 = i_op1[32*k +: 32];
            sel_op2 = i_op2[32*k +: 32];
         end
      end
   end

   always_comb begin : next_state
      state_d  = state_q;
      ptr_d    = ptr_q;
      id_d     = id_q;
      op_d     = op_q;
      op1_d    = op1_q;
      op2_d    = op2_q;
      result_d = result_q;
      cmp_d    = cmp_q;
      grant    = 1'b0;

      case (state_q)
         IDLE: begin
            if (found) begin
               grant   = 1'b1;
               state_d = EXECUTE;
            end
         end
         EXECUTE: begin
            result_d = i_alu_result;
            cmp_d    = i_alu_compare_result;
            state_d  = RESPOND;
         end
         RESPOND: begin
            if (!id_valid) begin
               state_d = IDLE;
            end else if (found) begin
               grant   = 1'b1;
               state_d = EXECUTE;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (grant) begin
         id_d  = IDW'(win_idx);
         op_d  = sel_op;
         op1_d = sel_op1;
         op2_d = sel_op2;
         ptr_d = (win_idx == REQUESTERS-1) ? '0 : IDW'(win_idx + 1);
      end
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state_q  <= IDLE;
         ptr_q    <= '0;
         id_q     <= '0;
         op_q     <= '0;
         op1_q    <= '0;
         op2_q    <= '0;
         result_q <= '0;
         cmp_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         id_q     <= id_d;
         op_q     <= op_d;
         op1_q    <= op1_d;
         op2_q    <= op2_d;
         result_q <= result_d;
         cmp_q    <= cmp_d;
      end
   end

   // ALU inputs come straight from the latched registers so they stay quiet
   // in IDLE.
   assign o_alu_op         = op_q;
   assign o_alu_op1        = op1_q;
   assign o_alu_op2        = op2_q;
   assign o_result         = result_q;
   assign o_compare_result = cmp_q;
   assign o_busy           = (state_q != IDLE);
   assign o_ready          = (state_q == RESPOND) ? id_onehot : '0;

`ifdef CPU_ALU_ARBITER_PERF_EN
   logic [REQUESTERS-1:0] grant_onehot;
   logic [31:0]           grant_cnt_q, stall_cnt_q;

   always_comb begin : perf_grant_vec
      grant_onehot = '0;
      for (int k = 0; k < REQUESTERS; k++) begin
         grant_onehot[k] = grant && (k == win_idx);
      end
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         grant_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (grant) grant_cnt_q <= grant_cnt_q + 32'd1;
         if (|(eligible & ~grant_onehot)) stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign o_grant_count = grant_cnt_q;
   assign o_stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_cpu_alu_arbiter.sv
// Purpose : directed self-checking bench for cpu_alu_arbiter (2 clients).
// Latency : inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpr. : clients hold their request until o_ready, then drop or keep it.
module tb_cpu_alu_arbiter;
   localparam int N = 2;
   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_SLT = 4'd2;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N-1:0]    req = '0;
   logic [4*N-1:0]  op  = '0;
   logic [32*N-1:0] op1 = '0;
   logic [32*N-1:0] op2 = '0;
   logic [N-1:0]    ready;
   logic [31:0]     result;
   logic            cmp;
   logic            busy;
   logic [3:0]      alu_op;
   logic [31:0]     alu_op1, alu_op2, alu_res;
   logic            alu_cmp;
`ifdef CPU_ALU_ARBITER_PERF_EN
   logic [31:0]     grant_cnt, stall_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   cpu_alu_arbiter #(.REQUESTERS(N), .IDW(3)) dut (
      .i_clock(clk), .i_reset(rst), .i_request(req),
      .i_op(op), .i_op1(op1), .i_op2(op2),
      .o_ready(ready), .o_result(result), .o_compare_result(cmp), .o_busy(busy),
      .o_alu_op(alu_op), .o_alu_op1(alu_op1), .o_alu_op2(alu_op2),
      .i_alu_result(alu_res), .i_alu_compare_result(alu_cmp)
`ifdef CPU_ALU_ARBITER_PERF_EN
      , .o_grant_count(grant_cnt), .o_stall_count(stall_cnt)
`endif
   );

   // Reference ALU: ADD, SUB, signed set-less-than (also drives the flag).
   always_comb begin
      alu_res = '0;
      alu_cmp = 1'b0;
      case (alu_op)
         OP_ADD: alu_res = alu_op1 + alu_op2;
         OP_SUB: alu_res = alu_op1 - alu_op2;
         OP_SLT: begin
            alu_cmp = ($signed(alu_op1) < $signed(alu_op2));
            alu_res = {31'b0, alu_cmp};
         end
         default: ;
      endcase
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int k, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
      op[4*k +: 4]   = o;
      op1[32*k +: 32] = a;
      op2[32*k +: 32] = b;
      req[k] = 1'b1;
   endtask

   task automatic drop(input int k);
      req[k] = 1'b0;
   endtask

   task automatic apply_reset();
      req = '0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      req = '0;
      tick();
      tick();
      checks++; if (ready !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b exp=00", ready); end
      checks++; if (result !== 32'd0) begin failures++; $display("FAIL reset_result got=%0h exp=0", result); end
      checks++; if (cmp !== 1'b0) begin failures++; $display("FAIL reset_cmp got=%b exp=0", cmp); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (alu_op !== 4'd0) begin failures++; $display("FAIL reset_alu_op got=%0h exp=0", alu_op); end
      checks++; if (alu_op1 !== 32'd0) begin failures++; $display("FAIL reset_alu_op1 got=%0h exp=0", alu_op1); end
      checks++; if (alu_op2 !== 32'd0) begin failures++; $display("FAIL reset_alu_op2 got=%0h exp=0", alu_op2); end
      rst = 1'b0;
      tick();
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle_busy got=%b exp=0", busy); end
   endtask

   task automatic test_single();
      set_req(0, OP_ADD, 32'd5, 32'd7);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_pre got=%b exp=0", busy); end
      tick();  // grant edge -> EXECUTE
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_exec got=%b exp=1", busy); end
      checks++; if (ready !== 2'b00) begin failures++; $display("FAIL single_ready_exec got=%b exp=00", ready); end
      checks++; if (alu_op !== OP_ADD) begin failures++; $display("FAIL single_alu_op got=%0h exp=0", alu_op); end
      checks++; if (alu_op1 !== 32'd5) begin failures++; $display("FAIL single_alu_op1 got=%0d exp=5", alu_op1); end
      checks++; if (alu_op2 !== 32'd7) begin failures++; $display("FAIL single_alu_op2 got=%0d exp=7", alu_op2); end
      tick();  // capture edge -> RESPOND
      checks++; if (ready !== 2'b01) begin failures++; $display("FAIL single_ready got=%b exp=01", ready); end
      checks++; if (result !== 32'd12) begin failures++; $display("FAIL single_result got=%0d exp=12", result); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_resp got=%b exp=1", busy); end
      drop(0);
      tick();  // back to IDLE
      checks++; if (ready !== 2'b00) begin failures++; $display("FAIL single_ready_after got=%b exp=00", ready); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_after got=%b exp=0", busy); end
      checks++; if (result !== 32'd12) begin failures++; $display("FAIL single_result_hold got=%0d exp=12", result); end
      checks++; if (alu_op1 !== 32'd5) begin failures++; $display("FAIL single_alu_hold got=%0d exp=5", alu_op1); end
   endtask

   task automatic test_two_clients();
      apply_reset();
      set_req(0, OP_ADD, 32'd1, 32'd2);
      set_req(1, OP_SUB, 32'd10, 32'd3);
      tick();
      checks++; if (alu_op1 !== 32'd1) begin failures++; $display("FAIL two_first_grant got=%0d exp=1", alu_op1); end
      checks++; if (ready !== 2'b00) begin failures++; $display("FAIL two_ready_e1 got=%b exp=00", ready); end
      tick();
      checks++; if (ready !== 2'b01) begin failures++; $display("FAIL two_ready0 got=%b exp=01", ready); end
      checks++; if (result !== 32'd3) begin failures++; $display("FAIL two_result0 got=%0d exp=3", result); end
      drop(0);
      tick();
      checks++; if (ready !== 2'b00) begin failures++; $display("FAIL two_ready_e3 got=%b exp=00", ready); end
      checks++; if (alu_op1 !== 32'd10) begin failures++; $display("FAIL two_second_grant got=%0d exp=10", alu_op1); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL two_busy_b2b got=%b exp=1", busy); end
      tick();
      checks++; if (ready !== 2'b10) begin failures++; $display("FAIL two_ready1 got=%b exp=10", ready); end
      checks++; if (result !== 32'd7) begin failures++; $display("FAIL two_result1 got=%0d exp=7", result); end
      drop(1);
      tick();
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL two_idle got=%b exp=0", busy); end
   endtask

   task automatic test_fairness();
      int n, last, cnt0, cnt1;
      logic [1:0]  exp_rdy;
      logic [31:0] exp_res;
      n = 0; last = 0; cnt0 = 0; cnt1 = 0;
      apply_reset();
      set_req(0, OP_ADD, 32'd100, 32'd1);
      set_req(1, OP_SUB, 32'd50, 32'd8);
      for (int cyc = 0; cyc < 40 && n < 8; cyc++) begin
         tick();
         if (ready !== 2'b00) begin
            exp_rdy = (n % 2 == 0) ? 2'b01 : 2'b10;
            exp_res = (n % 2 == 0) ? 32'd101 : 32'd42;
            checks++; if (ready !== exp_rdy) begin failures++; $display("FAIL fair_order n=%0d got=%b exp=%b", n, ready, exp_rdy); end
            checks++; if (result !== exp_res) begin failures++; $display("FAIL fair_result n=%0d got=%0d exp=%0d", n, result, exp_res); end
            if (n > 0) begin
               checks++; if (cyc - last != 2) begin failures++; $display("FAIL fair_spacing n=%0d got=%0d exp=2", n, cyc - last); end
            end
            if (ready == 2'b01) cnt0++;
            if (ready == 2'b10) cnt1++;
            last = cyc;
            n++;
         end
      end
      checks++; if (n != 8) begin failures++; $display("FAIL fair_timeout got=%0d exp=8", n); end
      checks++; if (cnt0 != 4) begin failures++; $display("FAIL fair_count0 got=%0d exp=4", cnt0); end
      checks++; if (cnt1 != 4) begin failures++; $display("FAIL fair_count1 got=%0d exp=4", cnt1); end
      tick();  // client 0 already granted again; drop both during its EXECUTE
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL fair_exec_busy got=%b exp=1", busy); end
      drop(0);
      drop(1);
      tick();
      checks++; if (ready !== 2'b01) begin failures++; $display("FAIL drop_after_grant_ready got=%b exp=01", ready); end
      checks++; if (result !== 32'd101) begin failures++; $display("FAIL drop_after_grant_result got=%0d exp=101", result); end
      tick();
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL fair_drain got=%b exp=0", busy); end
   endtask

   task automatic test_single_continuous();
      int n, last, gap_at;
      n = 0; last = 0; gap_at = -1;
      apply_reset();
      set_req(0, OP_ADD, 32'd5, 32'd7);
      for (int cyc = 0; cyc < 30 && n < 3; cyc++) begin
         tick();
         if (cyc == gap_at) begin
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL cont_gap_busy got=%b exp=0", busy); end
         end
         if (ready !== 2'b00) begin
            checks++; if (ready !== 2'b01) begin failures++; $display("FAIL cont_ready got=%b exp=01", ready); end
            if (n > 0) begin
               checks++; if (cyc - last != 3) begin failures++; $display("FAIL cont_spacing got=%0d exp=3", cyc - last); end
            end
            last   = cyc;
            gap_at = cyc + 1;
            n++;
         end
      end
      checks++; if (n != 3) begin failures++; $display("FAIL cont_timeout got=%0d exp=3", n); end
      drop(0);
      tick();
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL cont_stop_busy got=%b exp=0", busy); end
      tick();
      checks++; if (busy !== 1'b0 || ready !== 2'b00) begin failures++; $display("FAIL cont_stay_idle got=%b/%b exp=0/00", busy, ready); end
   endtask

   task automatic test_compare();
      int k;
      set_req(1, OP_SLT, 32'hFFFF_FFFF, 32'd1);
      for (k = 0; k < 10; k++) begin
         tick();
         if (ready !== 2'b00) break;
      end
      checks++; if (k == 10) begin failures++; $display("FAIL cmp_timeout got=%0d exp=<10", k); end
      checks++; if (ready !== 2'b10) begin failures++; $display("FAIL cmp_ready got=%b exp=10", ready); end
      checks++; if (cmp !== 1'b1) begin failures++; $display("FAIL cmp_flag got=%b exp=1", cmp); end
      checks++; if (result !== 32'd1) begin failures++; $display("FAIL cmp_result got=%0d exp=1", result); end
      drop(1);
      tick();
      checks++; if (cmp !== 1'b1) begin failures++; $display("FAIL cmp_hold1 got=%b exp=1", cmp); end
      tick();
      checks++; if (cmp !== 1'b1) begin failures++; $display("FAIL cmp_hold2 got=%b exp=1", cmp); end
      set_req(0, OP_ADD, 32'd3, 32'd4);
      for (k = 0; k < 10; k++) begin
         tick();
         if (ready !== 2'b00) break;
      end
      checks++; if (ready !== 2'b01) begin failures++; $display("FAIL cmp_next_ready got=%b exp=01", ready); end
      checks++; if (cmp !== 1'b0) begin failures++; $display("FAIL cmp_next_flag got=%b exp=0", cmp); end
      checks++; if (result !== 32'd7) begin failures++; $display("FAIL cmp_next_result got=%0d exp=7", result); end
      drop(0);
      tick();
   endtask

   task automatic test_drop_before_grant();
      set_req(0, OP_ADD, 32'd9, 32'd1);
      tick();                               // EXECUTE for client 0
      set_req(1, OP_SUB, 32'd9, 32'd1);     // raised, then dropped before any grant edge
      tick();                               // RESPOND for client 0
      checks++; if (ready !== 2'b01) begin failures++; $display("FAIL dropb_ready0 got=%b exp=01", ready); end
      checks++; if (result !== 32'd10) begin failures++; $display("FAIL dropb_result got=%0d exp=10", result); end
      drop(0);
      drop(1);
      tick();
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL dropb_busy got=%b exp=0", busy); end
      tick();
      checks++; if (busy !== 1'b0 || ready !== 2'b00) begin failures++; $display("FAIL dropb_ignored got=%b/%b exp=0/00", busy, ready); end
   endtask

   task automatic test_reset_mid();
      set_req(0, OP_ADD, 32'd2, 32'd3);
      tick();  // EXECUTE; pointer now points at client 1
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rmid_busy_pre got=%b exp=1", busy); end
      #2;
      rst = 1'b1;
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b exp=0", busy); end
      checks++; if (ready !== 2'b00) begin failures++; $display("FAIL rmid_ready got=%b exp=00", ready); end
      checks++; if (result !== 32'd0) begin failures++; $display("FAIL rmid_result got=%0d exp=0", result); end
      checks++; if (alu_op1 !== 32'd0 || alu_op2 !== 32'd0) begin failures++; $display("FAIL rmid_alu got=%0d/%0d exp=0/0", alu_op1, alu_op2); end
      drop(0);
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (ready !== 2'b00) begin failures++; $display("FAIL rmid_no_ready got=%b exp=00", ready); end
      end
      rst = 1'b0;
      set_req(0, OP_ADD, 32'd20, 32'd22);
      set_req(1, OP_SUB, 32'd20, 32'd2);
      tick();
      checks++; if (alu_op1 !== 32'd20 || alu_op !== OP_ADD) begin failures++; $display("FAIL rmid_ptr0 got=%0h/%0d exp=0/20", alu_op, alu_op1); end
      tick();
      checks++; if (ready !== 2'b01) begin failures++; $display("FAIL rmid_ready0 got=%b exp=01", ready); end
      checks++; if (result !== 32'd42) begin failures++; $display("FAIL rmid_result0 got=%0d exp=42", result); end
      drop(0);
      tick();
      tick();
      checks++; if (ready !== 2'b10) begin failures++; $display("FAIL rmid_ready1 got=%b exp=10", ready); end
      checks++; if (result !== 32'd18) begin failures++; $display("FAIL rmid_result1 got=%0d exp=18", result); end
      drop(1);
      tick();
   endtask

   initial begin
      test_reset();
      test_single();
      test_two_clients();
      test_fairness();
      test_single_continuous();
      test_compare();
      test_drop_before_grant();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
